// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register, load alignment/extension and register-file write-back
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Valid_MEM,
    input  logic              RegWriteOut_MEM,
    input  logic              MemToReg_MEM,
    input  logic [1:0]        R_Width_MEM,
    input  logic              LoadSigned_MEM,
    input  logic [DATA_W-1:0] ALUResult_MEM,
    input  logic [DATA_W-1:0] MemReadData_MEM,
    input  logic [REG_AW-1:0] rDestSelected_MEM,
    input  logic              Stall_WB,
    input  logic              Flush_WB,
    output logic              RegWrite,
    output logic [REG_AW-1:0] rDestSelected_ID,
    output logic [DATA_W-1:0] regWriteData,
    output logic              Valid_WB,
    output logic              MisalignErr,
    output logic [CNT_W-1:0]  InstRetired
);

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    logic              valid_q,    valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic [1:0]        width_q,    width_d;
    logic              lsigned_q,  lsigned_d;
    logic [DATA_W-1:0] alu_q,      alu_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic [REG_AW-1:0] rdest_q,    rdest_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic [1:0]        off;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [DATA_W-1:0] load_data;
    logic              misalign_now;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        width_d    = width_q;
        lsigned_d  = lsigned_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        rdest_d    = rdest_q;
        if (Flush_WB) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            width_d    = 2'b00;
            lsigned_d  = 1'b0;
            alu_d      = '0;
            rdata_d    = '0;
            rdest_d    = '0;
        end else if (!Stall_WB) begin
            valid_d    = Valid_MEM;
            regwrite_d = RegWriteOut_MEM;
            memtoreg_d = MemToReg_MEM;
            width_d    = R_Width_MEM;
            lsigned_d  = LoadSigned_MEM;
            alu_d      = ALUResult_MEM;
            rdata_d    = MemReadData_MEM;
            rdest_d    = rDestSelected_MEM;
        end
    end

    // Flush outranks stall, so an instruction that is flushed out still retires.
    always_comb begin
        cnt_d      = cnt_q;
        misalign_d = misalign_q | misalign_now;
        if (valid_q && (Flush_WB || !Stall_WB))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            width_q    <= 2'b00;
            lsigned_q  <= 1'b0;
            alu_q      <= '0;
            rdata_q    <= '0;
            rdest_q    <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            width_q    <= width_d;
            lsigned_q  <= lsigned_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            rdest_q    <= rdest_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign off = alu_q[1:0];

    always_comb begin
        half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (off)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
    end

    // Reserved width 2'b11 behaves as a word load.
    always_comb begin
        load_data    = rdata_q;
        misalign_now = 1'b0;
        case (width_q)
            W_HALF: begin
                load_data    = {{16{lsigned_q & half_sel[15]}}, half_sel};
                misalign_now = off[0];
            end
            W_BYTE: begin
                load_data    = {{24{lsigned_q & byte_sel[7]}}, byte_sel};
            end
            default: begin
                load_data    = rdata_q;
                misalign_now = (off != 2'b00);
            end
        endcase
        misalign_now = misalign_now & valid_q & memtoreg_q;
    end

    assign RegWrite         = valid_q & regwrite_q & (rdest_q != '0);
    assign rDestSelected_ID = rdest_q;
    assign regWriteData     = memtoreg_q ? load_data : alu_q;
    assign Valid_WB         = valid_q;
    assign MisalignErr      = misalign_q | misalign_now;
    assign InstRetired      = cnt_q;

endmodule
